// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding-select encodings, multiply latency bounds and a register-match helper.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_e;

    localparam logic [1:0] FW_REG = 2'b00;
    localparam logic [1:0] FW_MEM = 2'b01;
    localparam logic [1:0] FW_WB  = 2'b10;

    localparam int MUL_LAT_MIN = 2;
    localparam int MUL_LAT_MAX = 8;
    localparam int MCNT_W      = 3;

    // True when a later stage writes a non-x0 register that the given source reads.
    function automatic logic reg_hit(input logic i_en, input logic [4:0] i_rd,
                                     input logic [4:0] i_rs);
        return i_en && (i_rd != 5'd0) && (i_rd == i_rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register; MEM result beats WB result.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs_ex,
    input  logic [4:0] i_rd_mem,
    input  logic       i_wb_en_mem,
    input  logic [4:0] i_rd_wb,
    input  logic       i_wb_en_wb,
    output logic [1:0] o_sel
);

    always_comb begin
        if (reg_hit(i_wb_en_mem, i_rd_mem, i_rs_ex)) begin
            o_sel = FW_MEM;
        end else if (reg_hit(i_wb_en_wb, i_rd_wb, i_rs_ex)) begin
            o_sel = FW_WB;
        end else begin
            o_sel = FW_REG;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and multi-cycle
// multiply stalls, branch/jump flush, data-memory freeze and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_id,
    input  logic [4:0]  rs2_addr_id,
    input  logic [4:0]  rs1_addr_ex,
    input  logic [4:0]  rs2_addr_ex,
    input  logic [4:0]  rd_addr_ex,
    input  logic [4:0]  rd_addr_mem,
    input  logic [4:0]  rd_addr_wb,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic        wb_en_ex,
    input  logic        wb_en_mem,
    input  logic        wb_en_wb,
    input  logic [2:0]  is_load_ex,
    input  logic        mul_ex,
    input  logic        taken,
    input  logic        jump_ex,
    input  logic        dm_req_mem,
    input  logic        dm_ready,
    output logic [1:0]  mux1_sel,
    output logic [1:0]  mux2_sel,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        flush_id,
    output logic        pc_sel,
    output logic        mul_done,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    if ((MUL_LAT < MUL_LAT_MIN) || (MUL_LAT > MUL_LAT_MAX)) begin : g_bad_mul_lat
        $error("hazard_ctrl: MUL_LAT out of range");
    end

    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUL_LAT - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [MCNT_W-1:0]   r_mcnt;
    logic [MCNT_W-1:0]   w_next_mcnt;
    logic [31:0]         r_stall_cnt;
    logic [31:0]         r_flush_cnt;

    logic [1:0] w_fwd1_sel;
    logic [1:0] w_fwd2_sel;
    logic       w_freeze;
    logic       w_redirect;
    logic       w_load_use;
    logic       w_stall_if;
    logic       w_stall_id;
    logic       w_stall_ex;
    logic       w_bubble_ex;
    logic       w_bubble_mem;
    logic       w_flush_id;
    logic       w_pc_sel;
    logic       w_mul_done;

    fwd_unit u_fwd_rs1 (
        .i_rs_ex     (rs1_addr_ex),
        .i_rd_mem    (rd_addr_mem),
        .i_wb_en_mem (wb_en_mem),
        .i_rd_wb     (rd_addr_wb),
        .i_wb_en_wb  (wb_en_wb),
        .o_sel       (w_fwd1_sel)
    );

    fwd_unit u_fwd_rs2 (
        .i_rs_ex     (rs2_addr_ex),
        .i_rd_mem    (rd_addr_mem),
        .i_wb_en_mem (wb_en_mem),
        .i_rd_wb     (rd_addr_wb),
        .i_wb_en_wb  (wb_en_wb),
        .o_sel       (w_fwd2_sel)
    );

    assign w_freeze   = dm_req_mem & ~dm_ready;
    assign w_redirect = taken | jump_ex;
    assign w_load_use = (|is_load_ex) &&
                        ((rs1_used_id && reg_hit(wb_en_ex, rd_addr_ex, rs1_addr_id)) ||
                         (rs2_used_id && reg_hit(wb_en_ex, rd_addr_ex, rs2_addr_id)));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_mcnt  = r_mcnt;
        w_stall_if   = 1'b0;
        w_stall_id   = 1'b0;
        w_stall_ex   = 1'b0;
        w_bubble_ex  = 1'b0;
        w_bubble_mem = 1'b0;
        w_flush_id   = 1'b0;
        w_pc_sel     = 1'b0;
        w_mul_done   = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                // A pending data access holds the whole pipe and the FSM in place.
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_stall_ex = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_redirect) begin
                            w_flush_id  = 1'b1;
                            w_bubble_ex = 1'b1;
                            w_pc_sel    = 1'b1;
                        end else if (mul_ex) begin
                            w_stall_if   = 1'b1;
                            w_stall_id   = 1'b1;
                            w_stall_ex   = 1'b1;
                            w_bubble_mem = 1'b1;
                            w_next_mcnt  = MCNT_W'(1);
                            w_next_state = ST_MUL;
                        end else if (w_load_use) begin
                            w_stall_if  = 1'b1;
                            w_stall_id  = 1'b1;
                            w_bubble_ex = 1'b1;
                        end
                    end
                    ST_MUL: begin
                        if (r_mcnt == MCNT_LAST) begin
                            // Completing cycle returns to RUN without looking at mul_ex again.
                            w_mul_done   = 1'b1;
                            w_next_mcnt  = '0;
                            w_next_state = ST_RUN;
                        end else begin
                            w_stall_if   = 1'b1;
                            w_stall_id   = 1'b1;
                            w_stall_ex   = 1'b1;
                            w_bubble_mem = 1'b1;
                            w_next_mcnt  = r_mcnt + MCNT_W'(1);
                        end
                    end
                    default: begin
                        w_next_state = ST_RUN;
                        w_next_mcnt  = '0;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_mcnt      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_mcnt  <= w_next_mcnt;
            if (w_stall_if) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_id) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign mux1_sel   = rst ? FW_REG : w_fwd1_sel;
    assign mux2_sel   = rst ? FW_REG : w_fwd2_sel;
    assign stall_if   = w_stall_if;
    assign stall_id   = w_stall_id;
    assign stall_ex   = w_stall_ex;
    assign bubble_ex  = w_bubble_ex;
    assign bubble_mem = w_bubble_mem;
    assign flush_id   = w_flush_id;
    assign pc_sel     = w_pc_sel;
    assign mul_done   = w_mul_done;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, multi-cycle corner sequences
// and random traffic against a cycle-budget reference model (two multiply latencies).
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic       rs1_used, rs2_used, wb_ex, wb_mem, wb_wb;
        logic [2:0] is_load;
        logic       mul, taken, jump, dm_req, dm_ready, rst;
    } in_t;

    typedef struct packed {
        logic [1:0] m1, m2;
        logic       sif, sid, sex, bex, bmem, fid, pcs, mdone;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_id, rs2_addr_id, rs1_addr_ex, rs2_addr_ex;
    logic [4:0] rd_addr_ex, rd_addr_mem, rd_addr_wb;
    logic       rs1_used_id, rs2_used_id, wb_en_ex, wb_en_mem, wb_en_wb;
    logic [2:0] is_load_ex;
    logic       mul_ex, taken, jump_ex, dm_req_mem, dm_ready;

    logic [1:0]  a_mux1_sel, a_mux2_sel, b_mux1_sel, b_mux2_sel;
    logic        a_stall_if, a_stall_id, a_stall_ex, a_bubble_ex, a_bubble_mem;
    logic        a_flush_id, a_pc_sel, a_mul_done;
    logic        b_stall_if, b_stall_id, b_stall_ex, b_bubble_ex, b_bubble_mem;
    logic        b_flush_id, b_pc_sel, b_mul_done;
    logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Lane 0 models the MUL_LAT=4 instance, lane 1 the MUL_LAT=3 instance.
    int          lat  [2] = '{4, 3};
    int          left [2];
    int unsigned sc   [2];
    int unsigned fc   [2];
    vec_t        tbl[$];

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex),
        .rd_addr_ex(rd_addr_ex), .rd_addr_mem(rd_addr_mem), .rd_addr_wb(rd_addr_wb),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .wb_en_ex(wb_en_ex), .wb_en_mem(wb_en_mem), .wb_en_wb(wb_en_wb),
        .is_load_ex(is_load_ex), .mul_ex(mul_ex), .taken(taken), .jump_ex(jump_ex),
        .dm_req_mem(dm_req_mem), .dm_ready(dm_ready),
        .mux1_sel(a_mux1_sel), .mux2_sel(a_mux2_sel),
        .stall_if(a_stall_if), .stall_id(a_stall_id), .stall_ex(a_stall_ex),
        .bubble_ex(a_bubble_ex), .bubble_mem(a_bubble_mem),
        .flush_id(a_flush_id), .pc_sel(a_pc_sel), .mul_done(a_mul_done),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex),
        .rd_addr_ex(rd_addr_ex), .rd_addr_mem(rd_addr_mem), .rd_addr_wb(rd_addr_wb),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .wb_en_ex(wb_en_ex), .wb_en_mem(wb_en_mem), .wb_en_wb(wb_en_wb),
        .is_load_ex(is_load_ex), .mul_ex(mul_ex), .taken(taken), .jump_ex(jump_ex),
        .dm_req_mem(dm_req_mem), .dm_ready(dm_ready),
        .mux1_sel(b_mux1_sel), .mux2_sel(b_mux2_sel),
        .stall_if(b_stall_if), .stall_id(b_stall_id), .stall_ex(b_stall_ex),
        .bubble_ex(b_bubble_ex), .bubble_mem(b_bubble_mem),
        .flush_id(b_flush_id), .pc_sel(b_pc_sel), .mul_done(b_mul_done),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.dm_ready = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rs1_addr_id = v.rs1_id;  rs2_addr_id = v.rs2_id;
        rs1_addr_ex = v.rs1_ex;  rs2_addr_ex = v.rs2_ex;
        rd_addr_ex  = v.rd_ex;   rd_addr_mem = v.rd_mem;  rd_addr_wb = v.rd_wb;
        rs1_used_id = v.rs1_used; rs2_used_id = v.rs2_used;
        wb_en_ex    = v.wb_ex;   wb_en_mem   = v.wb_mem;  wb_en_wb   = v.wb_wb;
        is_load_ex  = v.is_load; mul_ex      = v.mul;
        taken       = v.taken;   jump_ex     = v.jump;
        dm_req_mem  = v.dm_req;  dm_ready    = v.dm_ready;
        rst         = v.rst;
    endtask

    function automatic out_t dut_out(input int k);
        if (k == 0)
            return out_t'({a_mux1_sel, a_mux2_sel, a_stall_if, a_stall_id, a_stall_ex,
                           a_bubble_ex, a_bubble_mem, a_flush_id, a_pc_sel, a_mul_done});
        return out_t'({b_mux1_sel, b_mux2_sel, b_stall_if, b_stall_id, b_stall_ex,
                       b_bubble_ex, b_bubble_mem, b_flush_id, b_pc_sel, b_mul_done});
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
        if (v.wb_mem && v.rd_mem != 0 && v.rd_mem == rs) return 2'b01;
        if (v.wb_wb && v.rd_wb != 0 && v.rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Model state is just "cycles of the current multiply still to run" (0 = idle).
    function automatic out_t ref_out(input in_t v, input int busy_left);
        out_t o;
        bit   frozen, lu;
        o      = '0;
        frozen = v.dm_req && !v.dm_ready;
        lu     = (v.is_load != 0) && v.wb_ex && (v.rd_ex != 0) &&
                 ((v.rs1_used && v.rs1_id == v.rd_ex) || (v.rs2_used && v.rs2_id == v.rd_ex));
        if (v.rst) return o;
        o.m1 = ref_fwd(v.rs1_ex, v);
        o.m2 = ref_fwd(v.rs2_ex, v);
        if (frozen) begin
            o.sif = 1; o.sid = 1; o.sex = 1;
        end else if (busy_left == 1) begin
            o.mdone = 1;
        end else if (busy_left > 1) begin
            o.sif = 1; o.sid = 1; o.sex = 1; o.bmem = 1;
        end else if (v.taken || v.jump) begin
            o.fid = 1; o.bex = 1; o.pcs = 1;
        end else if (v.mul) begin
            o.sif = 1; o.sid = 1; o.sex = 1; o.bmem = 1;
        end else if (lu) begin
            o.sif = 1; o.sid = 1; o.bex = 1;
        end
        return o;
    endfunction

    function automatic int ref_next(input in_t v, input int busy_left, input int l);
        if (v.rst) return 0;
        if (v.dm_req && !v.dm_ready) return busy_left;
        if (busy_left > 0) return busy_left - 1;
        if (!(v.taken || v.jump) && v.mul) return l - 1;
        return 0;
    endfunction

    // Apply one cycle of inputs, compare both instances to the model, advance the model.
    task automatic cycle(input in_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        for (int k = 0; k < 2; k++) begin
            out_t e;
            e = ref_out(v, left[k]);
            check($sformatf("%s/L%0d outs", tag, lat[k]), 32'(dut_out(k)), 32'(e));
            check($sformatf("%s/L%0d stall_cnt", tag, lat[k]),
                  (k == 0) ? a_stall_cnt : b_stall_cnt, sc[k]);
            check($sformatf("%s/L%0d flush_cnt", tag, lat[k]),
                  (k == 0) ? a_flush_cnt : b_flush_cnt, fc[k]);
            if (v.rst) begin
                sc[k] = 0; fc[k] = 0; left[k] = 0;
            end else begin
                sc[k]   = sc[k] + 32'(e.sif);
                fc[k]   = fc[k] + 32'(e.fid);
                left[k] = ref_next(v, left[k], lat[k]);
            end
        end
    endtask

    task automatic do_reset();
        in_t v;
        v = idle();
        v.rst = 1'b1;
        cycle(v, "reset");
    endtask

    task automatic add(input string n, input in_t v, input out_t e);
        vec_t t;
        t.name = n; t.i = v; t.o = e;
        tbl.push_back(t);
    endtask

    function automatic in_t rnd_vec();
        in_t v;
        v.rs1_id   = 5'($urandom_range(0, 7));
        v.rs2_id   = 5'($urandom_range(0, 7));
        v.rs1_ex   = 5'($urandom_range(0, 7));
        v.rs2_ex   = 5'($urandom_range(0, 7));
        v.rd_ex    = 5'($urandom_range(0, 7));
        v.rd_mem   = 5'($urandom_range(0, 7));
        v.rd_wb    = 5'($urandom_range(0, 7));
        v.rs1_used = ($urandom % 4) != 0;
        v.rs2_used = ($urandom % 4) != 0;
        v.wb_ex    = ($urandom % 4) != 0;
        v.wb_mem   = ($urandom % 3) != 0;
        v.wb_wb    = ($urandom % 3) != 0;
        v.is_load  = (($urandom % 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        v.mul      = ($urandom % 6) == 0;
        v.taken    = ($urandom % 8) == 0;
        v.jump     = ($urandom % 12) == 0;
        v.dm_req   = ($urandom % 3) == 0;
        v.dm_ready = ($urandom % 2) == 0;
        v.rst      = ($urandom % 60) == 0;
        return v;
    endfunction

    initial begin
        in_t  v, lu;
        out_t e;
        bit   done_exp [5] = '{0, 0, 0, 0, 1};

        // Reset state: all outputs low during the reset cycle.
        v = idle();
        v.rst = 1'b1;
        drive(v);
        @(negedge clk);
        #1;
        check("reset outs L4", 32'(dut_out(0)), 32'd0);
        check("reset outs L3", 32'(dut_out(1)), 32'd0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; sc[k] = 0; fc[k] = 0;
        end

        // Directed single-cycle table (RUN state).
        v = idle(); v.rd_mem = 5; v.wb_mem = 1; v.rd_wb = 5; v.wb_wb = 1; v.rs1_ex = 5;
        e = '0; e.m1 = 2'b01; add("fwd_mem_over_wb", v, e);
        v.rd_mem = 0;
        e = '0; e.m1 = 2'b10; add("fwd_wb_mem_x0", v, e);
        v = idle(); v.rs2_ex = 9; v.rd_wb = 9; v.wb_wb = 1; v.rd_mem = 9; v.wb_mem = 0;
        e = '0; e.m2 = 2'b10; add("fwd_rs2_wb", v, e);
        v = idle(); v.wb_mem = 1; v.wb_wb = 1;
        e = '0; add("fwd_x0_never", v, e);
        v = idle(); v.rs1_ex = 3; v.rs2_ex = 3; v.rd_mem = 3; v.wb_mem = 1;
        e = '0; e.m1 = 2'b01; e.m2 = 2'b01; add("fwd_both_mem", v, e);
        lu = idle(); lu.is_load = 3'b010; lu.wb_ex = 1; lu.rd_ex = 7; lu.rs2_id = 7; lu.rs2_used = 1;
        e = '0; e.sif = 1; e.sid = 1; e.bex = 1; add("loaduse_rs2", lu, e);
        v = lu; v.rs2_used = 0;
        e = '0; add("loaduse_unused", v, e);
        v = idle(); v.is_load = 1; v.wb_ex = 1; v.rs1_used = 1;
        e = '0; add("loaduse_x0", v, e);
        v = idle(); v.is_load = 1; v.rd_ex = 7; v.rs1_id = 7; v.rs1_used = 1;
        e = '0; add("loaduse_no_wb", v, e);
        v.is_load = 0; v.wb_ex = 1;
        e = '0; add("not_load", v, e);
        v = lu; v.taken = 1;
        e = '0; e.fid = 1; e.bex = 1; e.pcs = 1; add("taken_over_loaduse", v, e);
        v = idle(); v.jump = 1;
        add("jump", v, e);
        v.dm_req = 1; v.dm_ready = 0;
        e = '0; e.sif = 1; e.sid = 1; e.sex = 1; add("freeze_over_jump", v, e);
        v = idle(); v.dm_req = 1;
        e = '0; add("mem_ready", v, e);

        foreach (tbl[i]) begin
            cycle(tbl[i].i, tbl[i].name);
            check({tbl[i].name, " table L4"}, 32'(dut_out(0)), 32'(tbl[i].o));
            check({tbl[i].name, " table L3"}, 32'(dut_out(1)), 32'(tbl[i].o));
        end

        // Load-use: one stall cycle then normal flow, stall_cnt = 1.
        do_reset();
        cycle(lu, "lu_seq");
        check("lu_seq stall_if", 32'(a_stall_if), 32'd1);
        cycle(idle(), "lu_after");
        check("lu_after stall_if", 32'(a_stall_if), 32'd0);
        check("lu_after stall_cnt", a_stall_cnt, 32'd1);

        // MUL_LAT=4 with mul_ex held: three stalls, done on the fourth, then RUN.
        do_reset();
        v = idle(); v.mul = 1;
        for (int c = 0; c < 4; c++) begin
            cycle(v, $sformatf("mul4_c%0d", c));
            check($sformatf("mul4_c%0d stall_if", c), 32'(a_stall_if), 32'(c < 3));
            check($sformatf("mul4_c%0d mul_done", c), 32'(a_mul_done), 32'(c == 3));
        end
        cycle(idle(), "mul4_run");
        check("mul4_run stall_if", 32'(a_stall_if), 32'd0);
        check("mul4_run stall_cnt", a_stall_cnt, 32'd3);

        // Branch taken with a simultaneous load-use: flush wins.
        do_reset();
        v = lu; v.taken = 1;
        cycle(v, "br_lu");
        check("br_lu flush/bubble/pc/stall",
              32'({a_flush_id, a_bubble_ex, a_pc_sel, a_stall_if}), 32'b1110);
        cycle(idle(), "br_after");
        check("br_after flush_cnt", a_flush_cnt, 32'd1);

        // MUL_LAT=3 frozen for two cycles mid-multiply: done slips by two.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            v = idle();
            if (c == 0) v.mul = 1;
            if (c == 1 || c == 2) begin v.dm_req = 1; v.dm_ready = 0; end
            cycle(v, $sformatf("mulfrz_c%0d", c));
            check($sformatf("mulfrz_c%0d mul_done", c), 32'(b_mul_done), 32'(done_exp[c]));
            check($sformatf("mulfrz_c%0d stall_if", c), 32'(b_stall_if), 32'(c < 4));
        end

        // Reset during MUL and during freeze: no residual stall afterwards.
        do_reset();
        v = idle(); v.mul = 1;
        cycle(v, "rstmul_start");
        cycle(idle(), "rstmul_mid");
        v = idle(); v.rst = 1; v.mul = 1;
        cycle(v, "rstmul_rst");
        check("rstmul_rst outs", 32'(dut_out(0)), 32'd0);
        cycle(idle(), "rstmul_after");
        check("rstmul_after stalls", 32'({a_stall_if, a_stall_id, a_stall_ex, b_stall_if}), 32'd0);
        check("rstmul_after counters", a_stall_cnt | a_flush_cnt, 32'd0);
        v = idle(); v.dm_req = 1; v.dm_ready = 0;
        cycle(v, "rstfrz_frozen");
        v.rst = 1;
        cycle(v, "rstfrz_rst");
        cycle(idle(), "rstfrz_after");
        check("rstfrz_after stall_if", 32'(a_stall_if), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(rnd_vec(), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
